// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the BRAM port arbiter: FSM state encoding and requester IDs.
package mem_port_arbiter_pkg;

  localparam int unsigned ADDR_W_DEF = 14;
  localparam int unsigned DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } arb_state_e;

  typedef enum logic {
    REQ_FETCH = 1'b0,
    REQ_DATA  = 1'b1
  } req_id_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and BRAM-side signals of the arbiter, bundled for port connection.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32
);
  localparam int MASK_W = DATA_W / 8;

  logic              i_f_req;
  logic [ADDR_W-1:0] i_f_addr;
  logic              o_f_gnt;
  logic              o_f_rvalid;
  logic [DATA_W-1:0] o_f_rdata;

  logic              i_d_req;
  logic              i_d_we;
  logic [ADDR_W-1:0] i_d_addr;
  logic [DATA_W-1:0] i_d_wdata;
  logic [MASK_W-1:0] i_d_wmask;
  logic              o_d_gnt;
  logic              o_d_rvalid;
  logic [DATA_W-1:0] o_d_rdata;

  logic              o_mem_en;
  logic              o_mem_we;
  logic [MASK_W-1:0] o_mem_wmask;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [DATA_W-1:0] o_mem_wdata;
  logic [DATA_W-1:0] i_mem_rdata;

  modport slave (
    input  i_f_req, i_f_addr,
    output o_f_gnt, o_f_rvalid, o_f_rdata,
    input  i_d_req, i_d_we, i_d_addr, i_d_wdata, i_d_wmask,
    output o_d_gnt, o_d_rvalid, o_d_rdata,
    output o_mem_en, o_mem_we, o_mem_wmask, o_mem_addr, o_mem_wdata,
    input  i_mem_rdata
  );

  modport master (
    output i_f_req, i_f_addr,
    input  o_f_gnt, o_f_rvalid, o_f_rdata,
    output i_d_req, i_d_we, i_d_addr, i_d_wdata, i_d_wmask,
    input  o_d_gnt, o_d_rvalid, o_d_rdata,
    input  o_mem_en, o_mem_we, o_mem_wmask, o_mem_addr, o_mem_wdata,
    output i_mem_rdata
  );

endinterface

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Two-input round-robin picker: on a tie the requester not served last wins.
module rr_pick2
  import mem_port_arbiter_pkg::*;
(
  input  logic    req_f,
  input  logic    req_d,
  input  req_id_e last_grant,
  output logic    valid,
  output req_id_e winner
);

  // Select the winner among the asserted requests.
  always_comb begin
    valid  = req_f | req_d;
    winner = REQ_FETCH;
    if (req_f && req_d) begin
      if (last_grant == REQ_FETCH) begin
        winner = REQ_DATA;
      end else begin
        winner = REQ_FETCH;
      end
    end else if (req_d) begin
      winner = REQ_DATA;
    end else begin
      winner = REQ_FETCH;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one word-addressed BRAM port between instruction fetch and load/store,
// with round-robin arbitration and a single access in flight.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32
) (
  input  logic               i_clk,
  input  logic               i_rst,
  mem_port_arbiter_if.slave  bus
);

  localparam int MASK_W = DATA_W / 8;

  arb_state_e        state_r;
  arb_state_e        state_next_s;
  req_id_e           last_grant_r;
  req_id_e           owner_r;
  req_id_e           winner_s;
  logic              pick_valid_s;
  logic              grant_s;
  logic              grant_write_s;
  logic              rd_r;

  logic              f_gnt_r;
  logic              d_gnt_r;
  logic              f_rvalid_r;
  logic              d_rvalid_r;
  logic              mem_en_r;
  logic              mem_we_r;
  logic [MASK_W-1:0] mem_wmask_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [DATA_W-1:0] mem_wdata_r;
  logic [DATA_W-1:0] f_rdata_s;
  logic [DATA_W-1:0] d_rdata_s;

  rr_pick2 u_pick (
    .req_f      (bus.i_f_req),
    .req_d      (bus.i_d_req),
    .last_grant (last_grant_r),
    .valid      (pick_valid_s),
    .winner     (winner_s)
  );

  // A grant can only issue when no command is on the memory port this cycle.
  always_comb begin
    grant_s       = 1'b0;
    grant_write_s = 1'b0;
    if (state_r != ST_ACCESS) begin
      grant_s       = pick_valid_s;
      grant_write_s = pick_valid_s && (winner_s == REQ_DATA) && bus.i_d_we;
    end else begin
      grant_s       = 1'b0;
      grant_write_s = 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (grant_s) begin
          state_next_s = ST_ACCESS;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (rd_r) begin
          state_next_s = ST_RESP;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_RESP: begin
        if (grant_s) begin
          state_next_s = ST_ACCESS;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Memory command, grant pulses and ownership of the access in flight.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      mem_en_r     <= 1'b0;
      mem_we_r     <= 1'b0;
      mem_wmask_r  <= {MASK_W{1'b0}};
      mem_addr_r   <= {ADDR_W{1'b0}};
      mem_wdata_r  <= {DATA_W{1'b0}};
      f_gnt_r      <= 1'b0;
      d_gnt_r      <= 1'b0;
      owner_r      <= REQ_FETCH;
      last_grant_r <= REQ_DATA;
      rd_r         <= 1'b0;
    end else if (grant_s) begin
      mem_en_r     <= 1'b1;
      f_gnt_r      <= (winner_s == REQ_FETCH);
      d_gnt_r      <= (winner_s == REQ_DATA);
      owner_r      <= winner_s;
      last_grant_r <= winner_s;
      rd_r         <= !grant_write_s;
      if (winner_s == REQ_DATA) begin
        mem_addr_r <= bus.i_d_addr;
      end else begin
        mem_addr_r <= bus.i_f_addr;
      end
      // Write fields are zeroed for reads so a read never carries stale enables.
      if (grant_write_s) begin
        mem_we_r    <= 1'b1;
        mem_wmask_r <= bus.i_d_wmask;
        mem_wdata_r <= bus.i_d_wdata;
      end else begin
        mem_we_r    <= 1'b0;
        mem_wmask_r <= {MASK_W{1'b0}};
        mem_wdata_r <= {DATA_W{1'b0}};
      end
    end else begin
      mem_en_r    <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_wmask_r <= {MASK_W{1'b0}};
      f_gnt_r     <= 1'b0;
      d_gnt_r     <= 1'b0;
    end
  end

  // Read-valid pulses land in the cycle the BRAM presents the data.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      f_rvalid_r <= 1'b0;
      d_rvalid_r <= 1'b0;
    end else begin
      f_rvalid_r <= (state_r == ST_ACCESS) && rd_r && (owner_r == REQ_FETCH);
      d_rvalid_r <= (state_r == ST_ACCESS) && rd_r && (owner_r == REQ_DATA);
    end
  end

  // Route BRAM read data to the owner of the response; the other side reads 0.
  always_comb begin
    f_rdata_s = {DATA_W{1'b0}};
    d_rdata_s = {DATA_W{1'b0}};
    if (f_rvalid_r) begin
      f_rdata_s = bus.i_mem_rdata;
    end else if (d_rvalid_r) begin
      d_rdata_s = bus.i_mem_rdata;
    end else begin
      f_rdata_s = {DATA_W{1'b0}};
      d_rdata_s = {DATA_W{1'b0}};
    end
  end

  assign bus.o_f_gnt     = f_gnt_r;
  assign bus.o_f_rvalid  = f_rvalid_r;
  assign bus.o_f_rdata   = f_rdata_s;
  assign bus.o_d_gnt     = d_gnt_r;
  assign bus.o_d_rvalid  = d_rvalid_r;
  assign bus.o_d_rdata   = d_rdata_s;
  assign bus.o_mem_en    = mem_en_r;
  assign bus.o_mem_we    = mem_we_r;
  assign bus.o_mem_wmask = mem_wmask_r;
  assign bus.o_mem_addr  = mem_addr_r;
  assign bus.o_mem_wdata = mem_wdata_r;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single word-addressed BRAM port between the CPU instruction-fetch requester (read-only) and the load/store requester (read/write, byte mask).
- Sits between the cpu sequencer and memory and replaces the direct mem_read/mem_address drive.
- Round-robin arbitration, one outstanding access, registered memory command, and a read response that follows the BRAM's one-cycle latency.

Parameters:
- ADDR_W, 14, word-address width (matches BRAM depth).
- DATA_W, 32, word width; byte mask width is DATA_W/8.

Ports:
- i_clk  in  1  system clock; all state on posedge.
- i_rst  in  1  reset, asynchronous and active-high.
- i_f_req  in  1  fetch request; held, with address stable, until o_f_gnt.
- i_f_addr  in  ADDR_W  fetch word address.
- o_f_gnt  out  1  one-cycle pulse: fetch command issued to memory.
- o_f_rvalid  out  1  one-cycle pulse: o_f_rdata holds the fetched word.
- o_f_rdata  out  DATA_W  fetch read data.
- i_d_req  in  1  data request; held, with all fields stable, until o_d_gnt.
- i_d_we  in  1  1 = write, 0 = read.
- i_d_addr  in  ADDR_W  data word address.
- i_d_wdata  in  DATA_W  write data.
- i_d_wmask  in  DATA_W/8  byte-enable for writes.
- o_d_gnt  out  1  one-cycle pulse: data command issued.
- o_d_rvalid  out  1  one-cycle pulse: read data valid; never set for writes.
- o_d_rdata  out  DATA_W  data read data.
- o_mem_en  out  1  BRAM enable.
- o_mem_we  out  1  BRAM write enable.
- o_mem_wmask  out  DATA_W/8  BRAM byte enables.
- o_mem_addr  out  ADDR_W  BRAM word address.
- o_mem_wdata  out  DATA_W  BRAM write data.
- i_mem_rdata  in  DATA_W  BRAM read data, valid one cycle after the en cycle.

Behaviour:
- Reset (async assert): state=IDLE; last_grant=DATA; all outputs 0 (gnt, rvalid, mem_en, mem_we, mem_wmask, mem_addr, mem_wdata). Any pending read response is discarded: no rvalid after reset.
- FSM states:
  - IDLE: no access in flight.
  - ACCESS: mem_en high this cycle.
  - RESP: read data on i_mem_rdata this cycle.
- Arbitration in IDLE or RESP:
  - Only one requester asserted: grant it.
  - Both asserted: grant the requester != last_grant, then update last_grant. After reset, fetch therefore wins the first tie.
- Grant at edge E:
  - Registered into cycle E+1: o_mem_en=1, o_mem_addr, and o_mem_we/o_mem_wmask/o_mem_wdata (data writes only; 0 for reads). o_x_gnt=1 for that one cycle.
  - Next state ACCESS.
- ACCESS -> at the next edge: o_mem_en/o_mem_we/o_mem_wmask <= 0. Read goes to RESP; write goes to IDLE.
- RESP:
  - o_x_rvalid=1 (registered) for the owner of the read.
  - o_x_rdata = i_mem_rdata, combinational pass-through. The non-owner's rdata is don't-care and is driven 0.
  - A new grant may issue in this cycle; otherwise -> IDLE.
- Latency: request seen in cycle N -> gnt in N+1 -> rvalid in N+2. Peak throughput is one read per 2 cycles, and one write per 2 cycles.
- Requesters must drop or change req no earlier than the cycle after gnt. The arbiter never issues a second grant in the gnt cycle (ACCESS).
- A write with wmask=0 is still granted and consumes the slot; memory is unchanged.
- o_mem_addr and o_mem_wdata hold their last values when mem_en=0. mem_we is never high without mem_en.

Decomposition:
- Shared include memarb.vinc holds:
  - localparams for FSM state encodings (IDLE, ACCESS, RESP);
  - requester IDs (REQ_FETCH=0, REQ_DATA=1).
- One sub-module, rr_pick2: 2-input round-robin picker, combinational. Inputs: two requests and last_grant. Outputs: a grant-valid bit and the winner ID.

Test Plan:
- Reset, then a single fetch request: assert i_f_req, i_f_addr=0x0010, with BRAM word 0x0010=0xDEADBEEF -> o_mem_en=1 and o_mem_addr=0x0010 in N+1 with o_f_gnt=1; o_f_rvalid=1 and o_f_rdata=0xDEADBEEF in N+2; o_d_* stays 0.
- Data write then read: write addr 0x0200, wdata 0x11223344, wmask 4'b0101 over old 0xAABBCCDD -> one cycle of mem_we; no o_d_rvalid. A following read of 0x0200 -> o_d_rdata=0xAA22CC44.
- Simultaneous requests after reset, both held continuously: fetch addr 0x1, data read addr 0x2 -> grant order F, D, F, D; rvalid to the matching requester each time; no requester is granted twice in a row while the other waits.
- Back-to-back reads: fetch req re-asserted with a new address in the cycle after gnt -> the next gnt lands in the RESP cycle; exactly 2 cycles between consecutive o_f_gnt pulses.
- Reset mid-read: assert i_rst during ACCESS -> all outputs 0 immediately; no o_x_rvalid follows; after release, the first tie goes to fetch.
- Write with wmask=0 to 0x0300 holding 0x12345678 -> o_d_gnt pulses; a read-back returns 0x12345678.
